// File: rtl/au_addsub_v.sv
// au_addsub_v: registered two's-complement adder/subtractor with carry/borrow-in
// and signed-overflow flag. ARCH selects the carry network (0 ripple, 1 4-bit
// carry-lookahead, 2 Sklansky prefix, 3 Kogge-Stone prefix, other = ripple);
// all networks produce identical s and v.
module au_addsub_v #(
  parameter int WIDTH = 8,
  parameter int ARCH  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             add_sub,
  output logic [WIDTH-1:0] s,
  output logic             v
);

  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] sum;
  logic             cin;
  // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB
  logic [WIDTH:0]   c;

  // Subtraction is a + ~b + 1; the borrow-in flips the injected carry
  assign op2 = b ^ {WIDTH{add_sub}};
  assign cin = ci ^ add_sub;
  assign g   = a & op2;
  assign p   = a ^ op2;

  generate
    if (ARCH == 1) begin : g_cla
      localparam int NG = (WIDTH + 3) / 4;
      logic [NG*4-1:0] gx;
      logic [NG*4-1:0] px;

      // Pad the top group with g = p = 0 so unused lanes stay at a known 0
      always_comb begin
        gx = '0;
        px = '0;
        gx[WIDTH-1:0] = g;
        px[WIDTH-1:0] = p;
      end

      // Lookahead inside each 4-bit group, group carries chained between groups
      always_comb begin
        logic       cg;
        logic       gg;
        logic       pg;
        logic [3:0] g4;
        logic [3:0] p4;
        logic [4:1] cl;
        int         base;
        c    = '0;
        c[0] = cin;
        cg   = cin;
        for (int k = 0; k < NG; k++) begin
          base  = 4 * k;
          g4    = gx[base +: 4];
          p4    = px[base +: 4];
          cl[1] = g4[0] | (p4[0] & cg);
          cl[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & cg);
          cl[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                | (p4[2] & p4[1] & p4[0] & cg);
          gg    = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
                | (p4[3] & p4[2] & p4[1] & g4[0]);
          pg    = &p4;
          cl[4] = gg | (pg & cg);
          for (int j = 1; j <= 4; j++) begin
            if (base + j <= WIDTH) c[base + j] = cl[j];
          end
          cg = cl[4];
        end
      end
    end else if (ARCH == 2 || ARCH == 3) begin : g_pfx
      // Nodes beyond WIDTH-1 would only ever hold g = p = 0 and never feed a
      // lower index, so the tree is simply truncated at WIDTH
      localparam int LOG = $clog2(WIDTH);
      localparam bit SKL = (ARCH == 2);

      for (genvar l = 0; l <= LOG; l++) begin : stg
        logic [WIDTH-1:0] gg;
        logic [WIDTH-1:0] pp;
        if (l == 0) begin : leaf
          assign gg = g;
          assign pp = p;
        end else begin : lvl
          for (genvar i = 0; i < WIDTH; i++) begin : node
            localparam int D   = 1 << (l - 1);
            localparam bit ACT = SKL ? (((i >> (l - 1)) & 1) == 1) : (i >= D);
            if (ACT) begin : op
              // Sklansky: combine with top of lower half-block; KS: with i-D
              localparam int J = SKL ? (((i >> (l - 1)) << (l - 1)) - 1) : (i - D);
              assign gg[i] = stg[l-1].gg[i] | (stg[l-1].pp[i] & stg[l-1].gg[J]);
              assign pp[i] = stg[l-1].pp[i] & stg[l-1].pp[J];
            end else begin : pass
              assign gg[i] = stg[l-1].gg[i];
              assign pp[i] = stg[l-1].pp[i];
            end
          end
        end
      end

      assign c[0] = cin;
      for (genvar i = 0; i < WIDTH; i++) begin : co
        assign c[i+1] = stg[LOG].gg[i] | (stg[LOG].pp[i] & cin);
      end
    end else begin : g_rca
      // Plain ripple chain
      always_comb begin
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
          c[i+1] = g[i] | (p[i] & c[i]);
        end
      end
    end
  endgenerate

  assign sum = p ^ c[WIDTH-1:0];

  // Output stage: one-cycle latency, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
      v <= 1'b0;
    end else begin
      s <= sum;
      v <= c[WIDTH] ^ c[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_au_addsub_v.sv
// Bench for au_addsub_v: instances for widths 8, 32, 13 and 1 across ARCH 0-3
// share one stimulus stream and are compared against a signed-arithmetic model.
module tb_au_addsub_v;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        ci_in;
  logic        op_in;
  logic [31:0] s_all [16];
  logic        v_all [16];
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  function automatic int width_of(input int wi);
    case (wi)
      0:       return 8;
      1:       return 32;
      2:       return 13;
      default: return 1;
    endcase
  endfunction

  for (genvar wi = 0; wi < 4; wi++) begin : g_w
    for (genvar ar = 0; ar < 4; ar++) begin : g_a
      localparam int W = width_of(wi);
      logic [W-1:0] s_o;
      logic         v_o;
      au_addsub_v #(.WIDTH(W), .ARCH(ar)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a_in[W-1:0]),
        .b       (b_in[W-1:0]),
        .ci      (ci_in),
        .add_sub (op_in),
        .s       (s_o),
        .v       (v_o)
      );
      assign s_all[wi*4+ar] = 32'(s_o);
      assign v_all[wi*4+ar] = v_o;
    end
  end

  // Exact signed arithmetic on the low w bits, then wrap and range-check
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic c, input logic o,
                                output logic [31:0] es, output logic ev);
    longint m, half, sa, sb, r;
    m    = longint'(1) << w;
    half = m >> 1;
    sa   = longint'({32'b0, a}) & (m - 1);
    sb   = longint'({32'b0, b}) & (m - 1);
    if (sa >= half) sa = sa - m;
    if (sb >= half) sb = sb - m;
    r  = o ? (sa - sb - longint'(c)) : (sa + sb + longint'(c));
    ev = (r < -half) || (r >= half);
    es = 32'(r & (m - 1));
  endfunction

  task automatic check_all(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic c, input logic o);
    logic [31:0] es;
    logic        ev;
    for (int k = 0; k < 16; k++) begin
      model(width_of(k / 4), a, b, c, o, es, ev);
      n_assert++;
      assert (s_all[k] === es && v_all[k] === ev) else begin
        n_fail++;
        $error("FAIL %s w=%0d arch=%0d: got s=%h v=%b, expected s=%h v=%b",
               tag, width_of(k / 4), k % 4, s_all[k], v_all[k], es, ev);
      end
    end
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic c,
                      input logic o, input string tag);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    ci_in = c;
    op_in = o;
    @(posedge clk);
    #1;
    check_all(tag, a, b, c, o);
  endtask

  task automatic dir8(input string tag, input logic [7:0] es, input logic ev);
    for (int k = 0; k < 4; k++) begin
      n_assert++;
      assert (s_all[k][7:0] === es && v_all[k] === ev) else begin
        n_fail++;
        $error("FAIL %s arch=%0d: got s=%h v=%b, expected s=%h v=%b",
               tag, k, s_all[k][7:0], v_all[k], es, ev);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    for (int k = 0; k < 16; k++) begin
      n_assert++;
      assert (s_all[k] === 32'h0 && v_all[k] === 1'b0) else begin
        n_fail++;
        $error("FAIL %s w=%0d arch=%0d: got s=%h v=%b, expected s=0 v=0",
               tag, width_of(k / 4), k % 4, s_all[k], v_all[k]);
      end
    end
  endtask

  initial begin
    logic [31:0] r1, r2;
    logic [7:0]  bl [8];
    logic [3:0]  cv;

    rst_n = 1'b0;
    a_in  = $urandom;
    b_in  = $urandom;
    ci_in = 1'b1;
    op_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;

    step(32'h03, 32'h04, 1'b0, 1'b0, "add_3_4");     dir8("add_3_4", 8'h07, 1'b0);
    step(32'h7F, 32'h01, 1'b0, 1'b0, "pos_ovf");     dir8("pos_ovf", 8'h80, 1'b1);
    step(32'h80, 32'h01, 1'b0, 1'b1, "neg_ovf");     dir8("neg_ovf", 8'h7F, 1'b1);
    step(32'hFF, 32'hFF, 1'b1, 1'b0, "add_ff_ci");   dir8("add_ff_ci", 8'hFF, 1'b0);
    step(32'h00, 32'h00, 1'b1, 1'b1, "sub_borrow");  dir8("sub_borrow", 8'hFF, 1'b0);
    step(32'h00, 32'hFF, 1'b0, 1'b1, "sub_0_ff");    dir8("sub_0_ff", 8'h01, 1'b0);

    for (int i = 0; i < 16; i++) begin
      cv = 4'(i);
      step(cv[0] ? 32'hFFFF_FFFF : 32'h0, cv[1] ? 32'hFFFF_FFFF : 32'h0,
           cv[2], cv[3], "corner");
    end

    // Reset asserted between edges clears outputs at once and drops the pending result
    @(negedge clk);
    a_in  = $urandom;
    b_in  = $urandom;
    ci_in = 1'b1;
    op_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    @(posedge clk);
    #1;
    check_zero("reset_midstream_hold");
    @(negedge clk);
    rst_n = 1'b1;
    r1 = $urandom;
    r2 = $urandom;
    step(r1, r2, 1'b1, 1'b1, "after_reset");

    bl = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'h55, 8'hAA, 8'h00};
    for (int a = 0; a < 256; a++) begin
      for (int bi = 0; bi < 8; bi++) begin
        for (int co = 0; co < 4; co++) begin
          r1 = $urandom;
          r2 = $urandom;
          if (bi == 7) bl[7] = r2[7:0];
          cv = 4'(co);
          step({r1[31:8], 8'(a)}, {r2[31:8], bl[bi]}, cv[0], cv[1], "sweep");
        end
      end
    end

    repeat (10000) begin
      r1 = $urandom;
      r2 = $urandom;
      step(r1, r2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
